// File: rtl/adder32_err_pkg.sv
// Shared definitions for the adder32 partition error monitors: FSM state
// encoding, default sizing and a reference absolute-difference helper.
package adder32_err_pkg;

  localparam int W_DEFAULT = 5;
  localparam int N_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // |a - b| for the default slice width, via a (W+1)-bit two's-complement
  // difference; the magnitude never exceeds 2^W-1, so W bits suffice.
  function automatic logic [W_DEFAULT-1:0] abs_diff(input logic [W_DEFAULT-1:0] a,
                                                    input logic [W_DEFAULT-1:0] b);
    logic [W_DEFAULT:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[W_DEFAULT] ? (~diff[W_DEFAULT-1:0] + W_DEFAULT'(1)) : diff[W_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/adder32_err_absdiff.sv
// Combinational W-bit absolute difference and inequality flag, shared by the
// partition error monitors.
module adder32_err_absdiff #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d,
  output logic         neq
);

  logic [W:0] diff;

  // Sign bit of the widened difference selects between the value and its
  // two's-complement negation; the low W bits then hold the magnitude.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    d    = diff[W] ? (~diff[W-1:0] + W'(1)) : diff[W-1:0];
    neq  = (a != b);
  end

endmodule

// File: rtl/adder32_7_err_monitor.sv
// Windowed error statistics for the adder32_7 approximate partition: counts
// mismatches, sums and tracks the worst absolute error over N_SAMPLES accepted
// samples, then reports through a valid/ready handshake.
module adder32_7_err_monitor
  import adder32_err_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int N_SAMPLES = N_DEFAULT,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1),
  parameter int SUM_W     = W + $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx_in,
  input  logic [W-1:0]     exact_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [W-1:0]     max_abs_err
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             last_accept;
  logic             win_start;

  logic [W-1:0]     d_c;
  logic             neq_c;
  logic             v1;
  logic [W-1:0]     d1;
  logic             neq1;

  assign in_ready    = (state == RUN);
  assign res_valid   = (state == REPORT);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == CNT_W'(N_SAMPLES - 1));
  assign win_start   = (state == IDLE) && start;

  adder32_err_absdiff #(.W(W)) u_absdiff (
    .a   (approx_in),
    .b   (exact_in),
    .d   (d_c),
    .neq (neq_c)
  );

  // Next-state logic for the window sequencer.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      // in_ready is already low here, so stage 1 holds the final sample for
      // exactly this cycle and is empty after the edge.
      DRAIN:   state_nxt = REPORT;
      REPORT:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accepted-sample counter, cleared when a window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc_cnt <= '0;
    else if (win_start) acc_cnt <= '0;
    else if (accept)    acc_cnt <= acc_cnt + CNT_W'(1);
  end

  // Stage 1: register the per-sample magnitude and mismatch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      d1   <= '0;
      neq1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        d1   <= d_c;
        neq1 <= neq_c;
      end
    end
  end

  // Stage 2: fold stage-1 results into the window accumulators; they hold
  // between windows so the last report stays readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (win_start) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (v1) begin
      err_count   <= err_count + CNT_W'(neq1);
      sum_abs_err <= sum_abs_err + SUM_W'(d1);
      if (d1 > max_abs_err) max_abs_err <= d1;
    end
  end

endmodule

// File: tb/tb_adder32_7_err_monitor.sv
// Self-checking bench for adder32_7_err_monitor. Two instances (N_SAMPLES=4
// for directed windows, N_SAMPLES=256 for random windows) are compared every
// cycle against a window model built from the list of accepted samples.
module tb_adder32_7_err_monitor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Small instance, N_SAMPLES = 4
  logic       a_start, a_iv, a_rr, a_ir, a_rv;
  logic [4:0] a_ax, a_ex, a_max;
  logic [2:0] a_ec;
  logic [7:0] a_sum;

  // Large instance, N_SAMPLES = 256
  logic        b_start, b_iv, b_rr, b_ir, b_rv;
  logic [4:0]  b_ax, b_ex, b_max;
  logic [8:0]  b_ec;
  logic [13:0] b_sum;

  adder32_7_err_monitor #(.W(5), .N_SAMPLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_iv), .in_ready(a_ir),
    .approx_in(a_ax), .exact_in(a_ex), .res_valid(a_rv), .res_ready(a_rr),
    .err_count(a_ec), .sum_abs_err(a_sum), .max_abs_err(a_max)
  );

  adder32_7_err_monitor #(.W(5), .N_SAMPLES(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_iv), .in_ready(b_ir),
    .approx_in(b_ax), .exact_in(b_ex), .res_valid(b_rv), .res_ready(b_rr),
    .err_count(b_ec), .sum_abs_err(b_sum), .max_abs_err(b_max)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural window model ----------------
  // Each window is the list of accepted samples with the cycle they were
  // offered in; statistics become visible two cycles after acceptance, and
  // the report becomes visible two cycles after the final sample.
  int w_d   [2][256];
  int w_neq [2][256];
  int w_cyc [2][256];
  int w_n   [2];
  bit open_m[2];
  bit pend_m[2];
  int full_cyc[2];

  task automatic step(input int id, input int n, input logic rstn,
                      input logic start, input logic iv, input logic rr,
                      input logic ir, input logic rv,
                      input int ax, input int ex, input int ec, input int sm, input int mx);
    string p;
    int    e_ec, e_sm, e_mx;
    bit    e_rv, idle_before;
    p = (id == 0) ? "n4" : "n256";
    if (!rstn) begin
      w_n[id] = 0; open_m[id] = 0; pend_m[id] = 0;
    end
    e_ec = 0; e_sm = 0; e_mx = 0;
    for (int k = 0; k < w_n[id]; k++) begin
      if (w_cyc[id][k] <= cyc - 2) begin
        e_ec += w_neq[id][k];
        e_sm += w_d[id][k];
        if (w_d[id][k] > e_mx) e_mx = w_d[id][k];
      end
    end
    e_rv = pend_m[id] && (cyc >= full_cyc[id] + 2);
    check({p, ".in_ready"},    int'(ir), int'(open_m[id]));
    check({p, ".res_valid"},   int'(rv), int'(e_rv));
    check({p, ".err_count"},   ec, e_ec);
    check({p, ".sum_abs_err"}, sm, e_sm);
    check({p, ".max_abs_err"}, mx, e_mx);
    if (rstn) begin
      idle_before = !open_m[id] && !pend_m[id];
      if (e_rv && rr) pend_m[id] = 0;
      if (iv && open_m[id]) begin
        w_d  [id][w_n[id]] = (ax > ex) ? ax - ex : ex - ax;
        w_neq[id][w_n[id]] = (ax != ex) ? 1 : 0;
        w_cyc[id][w_n[id]] = cyc;
        w_n[id]++;
        if (w_n[id] == n) begin
          open_m[id] = 0; pend_m[id] = 1; full_cyc[id] = cyc;
        end
      end
      if (start && idle_before) begin
        w_n[id] = 0; open_m[id] = 1;
      end
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    step(0, 4, rst_n, a_start, a_iv, a_rr, a_ir, a_rv,
         int'(a_ax), int'(a_ex), int'(a_ec), int'(a_sum), int'(a_max));
    step(1, 256, rst_n, b_start, b_iv, b_rr, b_ir, b_rv,
         int'(b_ax), int'(b_ex), int'(b_ec), int'(b_sum), int'(b_max));
  end

  // ---------------- directed helpers (N_SAMPLES = 4) ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start4;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic send4(input logic [4:0] ax, input logic [4:0] ex, input bit st);
    bit got;
    a_iv = 1'b1; a_ax = ax; a_ex = ex; a_start = st;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = a_ir;
      tick();
    end
    a_iv = 1'b0; a_start = 1'b0;
    check("n4.sample_accepted", int'(got), 1);
  endtask

  task automatic wait_rv4;
    for (int t = 0; t < 8 && !a_rv; t++) tick();
    check("n4.res_valid_rise", int'(a_rv), 1);
  endtask

  // Window (5,5),(6,7),(0,31),(12,10): err=3, sum=0+1+31+2=34, max=31.
  task automatic window4(input bit toggle, input bit pulse_mid, input int hold);
    int ax_t[4];
    int ex_t[4];
    ax_t = '{5, 6, 0, 12};
    ex_t = '{5, 7, 31, 10};
    pulse_start4();
    for (int i = 0; i < 4; i++) begin
      send4(5'(ax_t[i]), 5'(ex_t[i]), pulse_mid && (i == 2));
      if (toggle) tick();
    end
    if (toggle) begin
      a_iv = 1'b1; a_ax = 5'd31; a_ex = 5'd0;
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        check("n4.fifth_not_ready", int'(a_ir), 0);
        tick();
      end
      a_iv = 1'b0;
    end
    wait_rv4();
    check("n4.err_count_lit",   int'(a_ec),  3);
    check("n4.sum_abs_err_lit", int'(a_sum), 34);
    check("n4.max_abs_err_lit", int'(a_max), 31);
    for (int t = 0; t < hold; t++) begin
      tick();
      check("n4.hold_res_valid", int'(a_rv),  1);
      check("n4.hold_sum",       int'(a_sum), 34);
    end
    if (pulse_mid) begin
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("n4.start_in_report_rv",  int'(a_rv), 1);
      check("n4.start_in_report_err", int'(a_ec), 3);
    end
    a_rr = 1'b1;
    tick();
    a_rr = 1'b0;
    check("n4.after_hs_res_valid", int'(a_rv),  0);
    check("n4.after_hs_in_ready",  int'(a_ir),  0);
    check("n4.idle_hold_sum",      int'(a_sum), 34);
    repeat (2) tick();
  endtask

  // Stand-in for the adder32_7 slice: exact 4-bit+4-bit+carry sum, and an
  // approximation that ORs the low two bits and drops the carry-in.
  task automatic gen_sample(output logic [4:0] ax, output logic [4:0] ex);
    logic [3:0] a, b;
    logic       ci;
    logic [2:0] hi;
    a  = 4'($urandom_range(15));
    b  = 4'($urandom_range(15));
    ci = 1'($urandom_range(1));
    ex = 5'(a) + 5'(b) + 5'(ci);
    hi = 3'(a[3:2]) + 3'(b[3:2]) + 3'(a[1] & b[1]);
    ax = {hi, a[1:0] | b[1:0]};
    if ($urandom_range(7) == 0) begin
      ax = 5'($urandom_range(31));
      ex = 5'($urandom_range(31));
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    a_start = 0; a_iv = 0; a_rr = 0; a_ax = 0; a_ex = 0;
    b_start = 0; b_iv = 0; b_rr = 0; b_ax = 0; b_ex = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("n4.reset_in_ready",  int'(a_ir), 0);
    check("n4.reset_res_valid", int'(a_rv), 0);

    // Reset mid-window after three accepts.
    pulse_start4();
    send4(5'd5, 5'd5, 1'b0);
    send4(5'd6, 5'd7, 1'b0);
    send4(5'd0, 5'd31, 1'b0);
    rst_n = 1'b0;
    #2;
    check("n4.midrst_err",      int'(a_ec),  0);
    check("n4.midrst_sum",      int'(a_sum), 0);
    check("n4.midrst_max",      int'(a_max), 0);
    check("n4.midrst_in_ready", int'(a_ir),  0);
    tick();
    rst_n = 1'b1;
    tick();
    check("n4.post_rst_in_ready", int'(a_ir), 0);

    window4(1'b0, 1'b0, 0);   // clean window, back-to-back
    window4(1'b1, 1'b0, 0);   // in_valid toggling, 5th sample offered
    window4(1'b0, 1'b0, 10);  // report held for 10 cycles
    window4(1'b0, 1'b1, 2);   // start pulsed during RUN and REPORT

    // Random windows on the 256-sample instance.
    for (int w = 0; w < 100; w++) begin
      int cnt;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      cnt = 0;
      for (int t = 0; t < 2000 && cnt < 256; t++) begin
        bit got;
        b_iv    = ($urandom_range(3) != 0);
        b_start = ($urandom_range(31) == 0);
        gen_sample(b_ax, b_ex);
        @(negedge clk);
        got = b_iv && b_ir;
        tick();
        if (got) cnt++;
      end
      b_iv = 1'b0; b_start = 1'b0;
      check("n256.window_filled", cnt, 256);
      for (int t = 0; t < 8 && !b_rv; t++) tick();
      check("n256.res_valid_rise", int'(b_rv), 1);
      repeat ($urandom_range(3)) tick();
      b_rr = 1'b1;
      tick();
      b_rr = 1'b0;
      check("n256.after_hs_res_valid", int'(b_rv), 0);
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
